// File: rtl/vend_pkg.sv
// Shared types for the cup-dispenser arbiter: FSM states, item codes, registered command bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_WAIT     = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic ITEM_TEA    = 1'b1;
  localparam logic ITEM_COFFEE = 1'b0;

  // Everything the arbiter pulses or drives toward panels and dispenser in one cycle.
  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] reject;
    logic       start;
    logic       item;
  } disp_cmd_t;

endpackage

// File: rtl/vend_dispense_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the panel that was not served last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the pick is consumed.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last,
  output logic [1:0] pick
);

  // One-hot pick; a tie alternates away from the last-served panel.
  always_comb begin
    pick = 2'b00;
    case (eligible)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one cup dispenser between two panels, tracks tea/coffee stock, rejects empty-item requests.
// Latency: req in IDLE -> gnt/disp_start next cycle; disp_done -> IDLE next cycle.
// Backpressure: req held by panel until gnt/reject; refill accepted only while load_ready (IDLE).
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int STOCK_W      = 4,
  parameter int MAX_STOCK    = 15,
  parameter int DISP_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [1:0]         req_item,
  output logic [1:0]         gnt,
  output logic [1:0]         reject,
  output logic               disp_start,
  output logic               disp_item,
  input  logic               disp_done,
  input  logic               load_valid,
  input  logic               load_item,
  input  logic [STOCK_W-1:0] load_count,
  output logic               load_ready,
  output logic [STOCK_W-1:0] tea_stock,
  output logic [STOCK_W-1:0] coffee_stock,
  output logic               tea_empty,
  output logic               coffee_empty,
  output logic               busy,
  output logic               fault
);

  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  localparam logic [STOCK_W-1:0] MAX_Q   = STOCK_W'(MAX_STOCK);
  localparam logic [TW-1:0]      TMO_END = TW'(DISP_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [STOCK_W-1:0] tea_q, tea_nxt;
  logic [STOCK_W-1:0] coffee_q, coffee_nxt;
  logic [TW-1:0]      timer_q, timer_nxt;
  logic               last_q, last_nxt;
  disp_cmd_t          cmd_q, cmd_nxt;

  logic [1:0]         stocked;
  logic [1:0]         eligible;
  logic [1:0]         pick;
  logic               win_item;
  logic [STOCK_W-1:0] load_base;
  logic [STOCK_W:0]   load_sum;
  logic [STOCK_W-1:0] load_sat;

  // Per-panel view of whether the requested item has at least one cup left.
  always_comb begin
    stocked[0] = (req_item[0] == ITEM_TEA) ? (tea_q != '0) : (coffee_q != '0);
    stocked[1] = (req_item[1] == ITEM_TEA) ? (tea_q != '0) : (coffee_q != '0);
    eligible   = req & stocked;
  end

  rr_arb2 u_arb (
    .eligible (eligible),
    .last     (last_q),
    .pick     (pick)
  );

  // Refill sum carries one extra bit so the clamp sees true overflow.
  always_comb begin
    load_base = (load_item == ITEM_TEA) ? tea_q : coffee_q;
    load_sum  = {1'b0, load_base} + {1'b0, load_count};
    load_sat  = (load_sum > {1'b0, MAX_Q}) ? MAX_Q : load_sum[STOCK_W-1:0];
    win_item  = pick[1] ? req_item[1] : req_item[0];
  end

  // Next-state, stock, timer and output-pulse decisions.
  always_comb begin
    state_nxt    = state;
    tea_nxt      = tea_q;
    coffee_nxt   = coffee_q;
    timer_nxt    = timer_q;
    last_nxt     = last_q;
    cmd_nxt      = '0;
    cmd_nxt.item = cmd_q.item;

    case (state)
      ST_IDLE: begin
        if (load_valid) begin
          // Refill takes the cycle; requests are looked at again next cycle.
          if (load_item == ITEM_TEA) tea_nxt = load_sat;
          else                       coffee_nxt = load_sat;
        end else begin
          // Rejects use pre-decrement stock, so a tie loser on the last cup waits one evaluation.
          cmd_nxt.reject = req & ~stocked;
          if (pick != 2'b00) begin
            cmd_nxt.gnt   = pick;
            cmd_nxt.start = 1'b1;
            cmd_nxt.item  = win_item;
            last_nxt      = pick[1];
            state_nxt     = ST_DISPENSE;
            if (win_item == ITEM_TEA) tea_nxt = tea_q - STOCK_W'(1);
            else                      coffee_nxt = coffee_q - STOCK_W'(1);
          end
        end
      end
      ST_DISPENSE: begin
        timer_nxt = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (disp_done)              state_nxt = ST_IDLE;
        else if (timer_q == TMO_END) state_nxt = ST_FAULT;
        else                        timer_nxt = timer_q + TW'(1);
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; a reset mid-dispense simply drops the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tea_q    <= '0;
      coffee_q <= '0;
      timer_q  <= '0;
      last_q   <= 1'b1;
      cmd_q    <= '0;
    end else begin
      state    <= state_nxt;
      tea_q    <= tea_nxt;
      coffee_q <= coffee_nxt;
      timer_q  <= timer_nxt;
      last_q   <= last_nxt;
      cmd_q    <= cmd_nxt;
    end
  end

  // Output mapping: pulses are registered, status flags decode the current state.
  always_comb begin
    gnt          = cmd_q.gnt;
    reject       = cmd_q.reject;
    disp_start   = cmd_q.start;
    disp_item    = cmd_q.item;
    tea_stock    = tea_q;
    coffee_stock = coffee_q;
    tea_empty    = (tea_q == '0);
    coffee_empty = (coffee_q == '0);
    load_ready   = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    fault        = (state == ST_FAULT);
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Bench for the cup-dispenser arbiter: directed scenarios then randomized traffic vs a cycle reference model.
// Latency: model predicts every output one edge ahead and compares on the falling edge.
// Backpressure: panels hold req until they see gnt or reject.
module tb_vend_dispense_arbiter;

  localparam int STOCK_W      = 4;
  localparam int MAX_STOCK    = 15;
  localparam int DISP_TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [1:0]         req_item;
  logic [1:0]         gnt;
  logic [1:0]         reject;
  logic               disp_start;
  logic               disp_item;
  logic               disp_done;
  logic               load_valid;
  logic               load_item;
  logic [STOCK_W-1:0] load_count;
  logic               load_ready;
  logic [STOCK_W-1:0] tea_stock;
  logic [STOCK_W-1:0] coffee_stock;
  logic               tea_empty;
  logic               coffee_empty;
  logic               busy;
  logic               fault;

  always #5 clk = ~clk;

  vend_dispense_arbiter #(
    .STOCK_W      (STOCK_W),
    .MAX_STOCK    (MAX_STOCK),
    .DISP_TIMEOUT (DISP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_item     (req_item),
    .gnt          (gnt),
    .reject       (reject),
    .disp_start   (disp_start),
    .disp_item    (disp_item),
    .disp_done    (disp_done),
    .load_valid   (load_valid),
    .load_item    (load_item),
    .load_count   (load_count),
    .load_ready   (load_ready),
    .tea_stock    (tea_stock),
    .coffee_stock (coffee_stock),
    .tea_empty    (tea_empty),
    .coffee_empty (coffee_empty),
    .busy         (busy),
    .fault        (fault)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cups per item (index 1 = tea, 0 = coffee) and service bookkeeping.
  int       m_stock [2];
  int       m_last;
  bit       m_serving;
  bit       m_first_cycle;
  int       m_budget;
  bit       m_fault;
  bit       m_item;
  bit [1:0] exp_gnt;
  bit [1:0] exp_reject;
  bit       exp_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit [1:0] g;
    bit [1:0] rj;
    bit       ds;
    bit       has [2];
    int       win;
    int       s;
    g  = '0;
    rj = '0;
    ds = 1'b0;
    if (rst) begin
      m_stock[0] = 0; m_stock[1] = 0;
      m_last = 1; m_serving = 0; m_first_cycle = 0;
      m_budget = 0; m_fault = 0; m_item = 0;
    end else if (m_fault) begin
      // nothing moves until reset
    end else if (m_serving) begin
      if (m_first_cycle) m_first_cycle = 0;
      else if (disp_done) m_serving = 0;
      else begin
        m_budget--;
        if (m_budget == 0) m_fault = 1;
      end
    end else if (load_valid) begin
      s = m_stock[load_item] + int'(load_count);
      m_stock[load_item] = (s > MAX_STOCK) ? MAX_STOCK : s;
    end else begin
      for (int j = 0; j < 2; j++) begin
        has[j] = req[j] && (m_stock[req_item[j]] > 0);
        if (req[j] && !has[j]) rj[j] = 1'b1;
      end
      win = -1;
      if (has[0] && has[1]) win = (m_last == 0) ? 1 : 0;
      else if (has[0])      win = 0;
      else if (has[1])      win = 1;
      if (win >= 0) begin
        g[win] = 1'b1;
        ds = 1'b1;
        m_item = req_item[win];
        m_stock[m_item]--;
        m_last = win;
        m_serving = 1;
        m_first_cycle = 1;
        m_budget = DISP_TIMEOUT;
      end
    end
    exp_gnt    = g;
    exp_reject = rj;
    exp_start  = ds;
  endtask

  task automatic compare_all();
    bit exp_busy;
    exp_busy = m_serving || m_fault;
    check("tea_stock",    tea_stock,    m_stock[1]);
    check("coffee_stock", coffee_stock, m_stock[0]);
    check("tea_empty",    tea_empty,    m_stock[1] == 0);
    check("coffee_empty", coffee_empty, m_stock[0] == 0);
    check("gnt",          gnt,          exp_gnt);
    check("reject",       reject,       exp_reject);
    check("disp_start",   disp_start,   exp_start);
    check("busy",         busy,         exp_busy);
    check("fault",        fault,        m_fault);
    check("load_ready",   load_ready,   !exp_busy);
    if (exp_busy) check("disp_item", disp_item, m_item);
  endtask

  // One clock: model sees the applied inputs, DUT takes the edge, outputs compared on the low phase.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic finish_dispense(input int wait_cycles);
    repeat (wait_cycles) tick();
    disp_done = 1'b1;
    tick();
    disp_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_item = '0; disp_done = 1'b0;
    load_valid = 1'b0; load_item = 1'b0; load_count = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_tea_empty", tea_empty, 1);
    rst = 1'b0;
    tick();

    // Refill tea 3, coffee 2.
    load_valid = 1'b1; load_item = 1'b1; load_count = 4'd3; tick();
    load_item = 1'b0; load_count = 4'd2; tick();
    load_valid = 1'b0; tick();
    check("load_tea3", tea_stock, 3);
    check("load_cof2", coffee_stock, 2);
    check("load_ready_idle", load_ready, 1);
    check("empties_clear", {tea_empty, coffee_empty}, 0);

    // Panel 0 tea: grant next cycle, done three cycles after grant.
    req = 2'b01; req_item = 2'b01; tick();
    check("p0_tea_gnt", gnt, 2'b01);
    check("p0_tea_start", disp_start, 1);
    check("p0_tea_stock", tea_stock, 2);
    req = 2'b00; finish_dispense(2);
    check("p0_tea_idle", busy, 0);

    // Panel 1 tea so the next tie favours panel 0.
    req = 2'b10; req_item = 2'b10; tick();
    check("p1_tea_gnt", gnt, 2'b10);
    req = 2'b00; finish_dispense(1);

    // Coffee tie with two cups: panel 0 first, panel 1 after.
    req = 2'b11; req_item = 2'b00; tick();
    check("tie_first", gnt, 2'b01);
    req = 2'b10; finish_dispense(1);
    tick();
    check("tie_second", gnt, 2'b10);
    req = 2'b00; finish_dispense(1);
    check("cof_drained", coffee_stock, 0);
    check("cof_empty", coffee_empty, 1);

    // Empty coffee: repeated reject, no start.
    req = 2'b10; req_item = 2'b00; tick();
    check("rej_1", reject, 2'b10);
    tick();
    check("rej_2", reject, 2'b10);
    check("rej_no_start", disp_start, 0);
    req = 2'b00; tick();

    // Saturating refill: tea 1 -> 14 -> 15.
    load_valid = 1'b1; load_item = 1'b1; load_count = 4'd13; tick();
    check("tea_14", tea_stock, 14);
    load_count = 4'd5; tick();
    check("tea_sat", tea_stock, 15);

    // Load and request together: load first, grant a cycle later.
    load_item = 1'b0; load_count = 4'd2; req = 2'b01; req_item = 2'b00; tick();
    check("ld_req_no_gnt", gnt, 0);
    check("ld_req_no_rej", reject, 0);
    load_valid = 1'b0; tick();
    check("ld_req_gnt", gnt, 2'b01);
    check("ld_req_cof", coffee_stock, 1);
    req = 2'b00; finish_dispense(1);

    // Timeout into fault.
    req = 2'b01; req_item = 2'b01; tick();
    req = 2'b00;
    repeat (DISP_TIMEOUT) tick();
    check("tmo_edge_nofault", fault, 0);
    tick();
    check("tmo_fault", fault, 1);
    check("tmo_busy", busy, 1);
    check("tmo_load_ready", load_ready, 0);
    req = 2'b11; req_item = 2'b11; load_valid = 1'b1; load_item = 1'b1; load_count = 4'd1;
    repeat (4) tick();
    check("fault_no_gnt", gnt, 0);
    check("fault_tea_held", tea_stock, 14);
    req = 2'b00; load_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    check("rst_fault_clr", fault, 0);
    check("rst_tea_zero", tea_stock, 0);

    // Randomized traffic; panels hold req until answered.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int j = 0; j < 2; j++) begin
        if (!(req[j] && !(exp_gnt[j] || exp_reject[j]))) begin
          req[j]      = ($urandom_range(0, 2) == 0);
          req_item[j] = 1'($urandom_range(0, 1));
        end
      end
      load_valid = ($urandom_range(0, 7) == 0);
      load_item  = 1'($urandom_range(0, 1));
      load_count = STOCK_W'($urandom_range(0, 15));
      disp_done  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
